// File: rtl/ex_stage_pkg.sv
// Shared constants for the EX stage: operation bus encoding, stall bus layout and M-unit states.
package ex_stage_pkg;

  localparam int unsigned OptBusW   = 8;
  localparam int unsigned StallBusW = 6;
  localparam int unsigned StallEx   = 3;

  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [OptBusW-1:0] opt_t;

  localparam opt_t OpNop    = 8'h00;
  localparam opt_t OpAdd    = 8'h01;
  localparam opt_t OpSub    = 8'h02;
  localparam opt_t OpSll    = 8'h03;
  localparam opt_t OpSlt    = 8'h04;
  localparam opt_t OpSltu   = 8'h05;
  localparam opt_t OpXor    = 8'h06;
  localparam opt_t OpSrl    = 8'h07;
  localparam opt_t OpSra    = 8'h08;
  localparam opt_t OpOr     = 8'h09;
  localparam opt_t OpAnd    = 8'h0a;
  localparam opt_t OpAddi   = 8'h11;
  localparam opt_t OpSlli   = 8'h13;
  localparam opt_t OpSlti   = 8'h14;
  localparam opt_t OpSltiu  = 8'h15;
  localparam opt_t OpXori   = 8'h16;
  localparam opt_t OpSrli   = 8'h17;
  localparam opt_t OpSrai   = 8'h18;
  localparam opt_t OpOri    = 8'h19;
  localparam opt_t OpAndi   = 8'h1a;
  localparam opt_t OpLui    = 8'h20;
  localparam opt_t OpAuipc  = 8'h21;
  localparam opt_t OpJal    = 8'h22;
  localparam opt_t OpJalr   = 8'h23;
  localparam opt_t OpBeq    = 8'h28;
  localparam opt_t OpBne    = 8'h29;
  localparam opt_t OpBlt    = 8'h2a;
  localparam opt_t OpBge    = 8'h2b;
  localparam opt_t OpBltu   = 8'h2c;
  localparam opt_t OpBgeu   = 8'h2d;
  localparam opt_t OpLb     = 8'h30;
  localparam opt_t OpLh     = 8'h31;
  localparam opt_t OpLw     = 8'h32;
  localparam opt_t OpLbu    = 8'h33;
  localparam opt_t OpLhu    = 8'h34;
  localparam opt_t OpSb     = 8'h38;
  localparam opt_t OpSh     = 8'h39;
  localparam opt_t OpSw     = 8'h3a;
  localparam opt_t OpMul    = 8'h40;
  localparam opt_t OpMulh   = 8'h41;
  localparam opt_t OpMulhsu = 8'h42;
  localparam opt_t OpMulhu  = 8'h43;
  localparam opt_t OpDiv    = 8'h44;
  localparam opt_t OpDivu   = 8'h45;
  localparam opt_t OpRem    = 8'h46;
  localparam opt_t OpRemu   = 8'h47;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  function automatic logic is_mul_op(input opt_t op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
  endfunction

  function automatic logic is_div_op(input opt_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Sequential RV32M unit: shift-add multiplier and restoring divider over operand magnitudes.
// The divider is only compiled when RV32M_DIV_EN is defined.
module ex_muldiv
  import ex_stage_pkg::*;
#(
  parameter int unsigned MD_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        hold,
  input  logic        start,
  input  opt_t        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned CntW = $clog2(MD_ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(MD_ITER - 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [31:0]     opb_q, opb_d;
  opt_t            op_q, op_d;
  logic            neg_q, neg_d;
`ifdef RV32M_DIV_EN
  logic            rem_neg_q, rem_neg_d;
  logic            dz_q, dz_d;
`endif

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] step;
  logic [63:0] prod;

  assign a_signed = op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  assign b_signed = op inside {OpMul, OpMulh, OpDiv, OpRem};
  assign a_neg    = a_signed & opa[31];
  assign b_neg    = b_signed & opb[31];
  assign mag_a    = a_neg ? -opa : opa;
  assign mag_b    = b_neg ? -opb : opb;

  // acc holds {partial product, remaining multiplier} and shifts right each iteration
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

`ifdef RV32M_DIV_EN
  logic        div_ge;
  logic [31:0] div_rem;
  // acc holds {remainder, quotient}; trial remainder is 33 bits after the left shift
  assign div_ge  = acc_q[63:31] >= {1'b0, opb_q};
  assign div_rem = acc_q[62:31] - opb_q;

  always_comb begin
    step = {mul_sum, acc_q[31:1]};
    if (is_div_op(op_q)) begin
      step = div_ge ? {div_rem, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    end
  end
`else
  assign step = {mul_sum, acc_q[31:1]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
`ifdef RV32M_DIV_EN
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = '0;
          acc_d   = {32'h0, mag_a};
          opb_d   = mag_b;
          op_d    = op;
          neg_d   = a_neg ^ b_neg;
`ifdef RV32M_DIV_EN
          rem_neg_d = a_neg;
          dz_d      = (opb == ZeroWord);
`endif
        end
      end
      StBusy: begin
        acc_d = step;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (!hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= OpNop;
      neg_q   <= 1'b0;
`ifdef RV32M_DIV_EN
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
`ifdef RV32M_DIV_EN
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);
  assign prod = neg_q ? -acc_q : acc_q;

  always_comb begin
    result = ZeroWord;
    if (state_q == StDone) begin
      case (op_q)
        OpMul:                     result = prod[31:0];
        OpMulh, OpMulhsu, OpMulhu: result = prod[63:32];
`ifdef RV32M_DIV_EN
        OpDiv, OpDivu: result = dz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
        OpRem, OpRemu: result = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
`endif
        default:       result = ZeroWord;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: combinational ALU/branch resolver plus the sequential M unit.
// RV32M_DIV_EN selects whether divide opcodes use the sequential divider.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MD_ITER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [31:0]          ex_pc,
  input  logic [OptBusW-1:0]   ex_inst,
  input  logic [31:0]          ex_vs1,
  input  logic [31:0]          ex_vs2,
  input  logic [4:0]           ex_rd,
  input  logic [31:0]          ex_imm,
  input  logic                 ex_w_enable,
  input  logic [StallBusW-1:0] stall_ctrler,
  output logic                 ex_stall_req,
  output logic                 jump_enable,
  output logic [31:0]          jump_addr,
  output logic [OptBusW-1:0]   mem_inst,
  output logic [4:0]           mem_rd,
  output logic                 mem_w_enable,
  output logic [31:0]          mem_wdata,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_sdata
);

  logic        is_m, md_busy, md_done;
  logic [31:0] md_result;
  logic [31:0] br_target, ls_addr, link_addr;
  logic        br_taken;

`ifdef RV32M_DIV_EN
  assign is_m = is_mul_op(ex_inst) | is_div_op(ex_inst);
`else
  assign is_m = is_mul_op(ex_inst);
`endif

  // Stall covers the issue cycle in IDLE and every BUSY cycle, but not DONE
  assign ex_stall_req = (is_m & ~md_busy & ~md_done) | md_busy;

  ex_muldiv #(
    .MD_ITER(MD_ITER)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .hold  (stall_ctrler[StallEx]),
    .start (is_m),
    .op    (ex_inst),
    .opa   (ex_vs1),
    .opb   (ex_vs2),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_result)
  );

  assign br_target = ex_pc + ex_imm;
  assign ls_addr   = ex_vs1 + ex_imm;
  assign link_addr = ex_pc + 32'd4;

  assign mem_inst     = ex_inst;
  assign mem_rd       = ex_rd;
  assign mem_w_enable = ex_w_enable;

  always_comb begin
    case (ex_inst)
      OpBeq:   br_taken = (ex_vs1 == ex_vs2);
      OpBne:   br_taken = (ex_vs1 != ex_vs2);
      OpBlt:   br_taken = ($signed(ex_vs1) < $signed(ex_vs2));
      OpBge:   br_taken = ($signed(ex_vs1) >= $signed(ex_vs2));
      OpBltu:  br_taken = (ex_vs1 < ex_vs2);
      OpBgeu:  br_taken = (ex_vs1 >= ex_vs2);
      default: br_taken = Disable;
    endcase
  end

  always_comb begin
    jump_enable = Disable;
    jump_addr   = ZeroWord;
    mem_wdata   = ZeroWord;
    mem_addr    = ZeroWord;
    mem_sdata   = ZeroWord;
    case (ex_inst)
      OpAdd:   mem_wdata = ex_vs1 + ex_vs2;
      OpSub:   mem_wdata = ex_vs1 - ex_vs2;
      OpSll:   mem_wdata = ex_vs1 << ex_vs2[4:0];
      OpSlt:   mem_wdata = {31'h0, $signed(ex_vs1) < $signed(ex_vs2)};
      OpSltu:  mem_wdata = {31'h0, ex_vs1 < ex_vs2};
      OpXor:   mem_wdata = ex_vs1 ^ ex_vs2;
      OpSrl:   mem_wdata = ex_vs1 >> ex_vs2[4:0];
      OpSra:   mem_wdata = $signed(ex_vs1) >>> ex_vs2[4:0];
      OpOr:    mem_wdata = ex_vs1 | ex_vs2;
      OpAnd:   mem_wdata = ex_vs1 & ex_vs2;
      OpAddi:  mem_wdata = ls_addr;
      OpSlli:  mem_wdata = ex_vs1 << ex_imm[4:0];
      OpSlti:  mem_wdata = {31'h0, $signed(ex_vs1) < $signed(ex_imm)};
      OpSltiu: mem_wdata = {31'h0, ex_vs1 < ex_imm};
      OpXori:  mem_wdata = ex_vs1 ^ ex_imm;
      OpSrli:  mem_wdata = ex_vs1 >> ex_imm[4:0];
      OpSrai:  mem_wdata = $signed(ex_vs1) >>> ex_imm[4:0];
      OpOri:   mem_wdata = ex_vs1 | ex_imm;
      OpAndi:  mem_wdata = ex_vs1 & ex_imm;
      OpLui:   mem_wdata = ex_imm;
      OpAuipc: mem_wdata = br_target;
      OpJal: begin
        jump_enable = Enable;
        jump_addr   = br_target;
        mem_wdata   = link_addr;
      end
      OpJalr: begin
        jump_enable = Enable;
        jump_addr   = ls_addr & 32'hFFFF_FFFE;
        mem_wdata   = link_addr;
      end
      OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: begin
        jump_enable = br_taken;
        jump_addr   = br_taken ? br_target : ZeroWord;
      end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: mem_addr = ls_addr;
      OpSb, OpSh, OpSw: begin
        mem_addr  = ls_addr;
        mem_sdata = ex_vs2;
      end
      default: begin
        // Divides without the divider fall through here and leave mem_wdata at zero
        if (is_m) mem_wdata = md_result;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU/branch vectors and M-unit latency, hold, reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 rdy;
  logic [31:0]          ex_pc;
  opt_t                 ex_inst;
  logic [31:0]          ex_vs1;
  logic [31:0]          ex_vs2;
  logic [4:0]           ex_rd;
  logic [31:0]          ex_imm;
  logic                 ex_w_enable;
  logic [StallBusW-1:0] stall_ctrler;
  logic                 ex_stall_req;
  logic                 jump_enable;
  logic [31:0]          jump_addr;
  opt_t                 mem_inst;
  logic [4:0]           mem_rd;
  logic                 mem_w_enable;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_sdata;

  int n_pass  = 0;
  int n_total = 0;

  ex_stage #(
    .MD_ITER(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .ex_pc       (ex_pc),
    .ex_inst     (ex_inst),
    .ex_vs1      (ex_vs1),
    .ex_vs2      (ex_vs2),
    .ex_rd       (ex_rd),
    .ex_imm      (ex_imm),
    .ex_w_enable (ex_w_enable),
    .stall_ctrler(stall_ctrler),
    .ex_stall_req(ex_stall_req),
    .jump_enable (jump_enable),
    .jump_addr   (jump_addr),
    .mem_inst    (mem_inst),
    .mem_rd      (mem_rd),
    .mem_w_enable(mem_w_enable),
    .mem_wdata   (mem_wdata),
    .mem_addr    (mem_addr),
    .mem_sdata   (mem_sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  task automatic set_inst(input opt_t op, input logic [31:0] pc, input logic [31:0] vs1,
                          input logic [31:0] vs2, input logic [31:0] imm);
    ex_inst = op;
    ex_pc   = pc;
    ex_vs1  = vs1;
    ex_vs2  = vs2;
    ex_imm  = imm;
    #1;
  endtask

  // Called just after an edge with the M unit idle; returns just after the edge entering DONE.
  task automatic run_mop(input string tag, input opt_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_inst(op, 32'h300, a, b, 32'h0);
    check({tag, " stall at issue"}, 32'(ex_stall_req), 32'd1);
    check({tag, " no jump"}, 32'(jump_enable), 32'd0);
    n = 1;
    while (n < 60) begin
      @(posedge clk);
      #1;
      if (!ex_stall_req) break;
      n++;
    end
    check({tag, " stall cycles"}, 32'(n), 32'd33);
    check({tag, " result"}, mem_wdata, exp);
  endtask

  initial begin
    rst          = 1'b0;
    rdy          = 1'b1;
    ex_pc        = '0;
    ex_inst      = OpNop;
    ex_vs1       = '0;
    ex_vs2       = '0;
    ex_rd        = '0;
    ex_imm       = '0;
    ex_w_enable  = 1'b0;
    stall_ctrler = '0;
    #2;
    check("reset stall_req", 32'(ex_stall_req), 32'd0);
    check("reset jump", {31'h0, jump_enable} | jump_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset mem_addr/sdata", mem_addr | mem_sdata, 32'd0);
    check("reset mem_inst/rd/we", {18'h0, mem_inst, mem_rd, mem_w_enable}, 32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    ex_rd       = 5'd7;
    ex_w_enable = 1'b1;
    set_inst(OpAdd, 32'h0, 32'd3, 32'd4, 32'h0);
    check("ADD result", mem_wdata, 32'd7);
    check("ADD passthrough", {18'h0, mem_inst, mem_rd, mem_w_enable}, {18'h0, OpAdd, 5'd7, 1'b1});
    set_inst(OpSra, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
    check("SRA result", mem_wdata, 32'hF800_0000);
    set_inst(OpSw, 32'h0, 32'h1000, 32'hDEAD_BEEF, 32'h8);
    check("SW addr", mem_addr, 32'h1008);
    check("SW sdata", mem_sdata, 32'hDEAD_BEEF);

    set_inst(OpBeq, 32'h100, 32'd5, 32'd5, 32'h20);
    check("BEQ taken enable", 32'(jump_enable), 32'd1);
    check("BEQ taken addr", jump_addr, 32'h120);
    set_inst(OpBne, 32'h100, 32'd5, 32'd5, 32'h20);
    check("BNE not taken", 32'(jump_enable), 32'd0);
    set_inst(OpBlt, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    check("BLT signed taken", 32'(jump_enable), 32'd1);
    set_inst(OpBltu, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    check("BLTU not taken", 32'(jump_enable), 32'd0);
    set_inst(OpJal, 32'h200, 32'h0, 32'h0, 32'h10);
    check("JAL addr", jump_addr, 32'h210);
    check("JAL link", mem_wdata, 32'h204);
    set_inst(OpJalr, 32'h400, 32'h203, 32'h0, 32'h0);
    check("JALR enable", 32'(jump_enable), 32'd1);
    check("JALR addr", jump_addr, 32'h202);
    check("JALR link", mem_wdata, 32'h404);

    @(posedge clk);
    #1;
    run_mop("MUL", OpMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    run_mop("MULHU", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    run_mop("MULH", OpMulh, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

    stall_ctrler = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold no restart", 32'(ex_stall_req), 32'd0);
      check("hold result", mem_wdata, 32'hFFFF_FFFF);
    end
    stall_ctrler = '0;
    @(posedge clk);
    #1;
    // Same opcode still on ex_inst: a fresh issue stall shows the unit went back to idle
    check("hold release idle", 32'(ex_stall_req), 32'd1);
    set_inst(OpNop, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

`ifdef RV32M_DIV_EN
    run_mop("DIV neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    run_mop("REM neg", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    run_mop("DIVU by 0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    run_mop("REMU by 0", OpRemu, 32'd5, 32'd0, 32'd5);
    @(posedge clk);
    #1;
    run_mop("DIV overflow", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    @(posedge clk);
    #1;
`else
    set_inst(OpDivu, 32'h0, 32'd5, 32'd0, 32'h0);
    check("DIVU off stall", 32'(ex_stall_req), 32'd0);
    check("DIVU off result", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    check("DIVU off no start", 32'(ex_stall_req), 32'd0);
`endif

    set_inst(OpMul, 32'h300, 32'd7, 32'hFFFF_FFFD, 32'h0);
    repeat (11) @(posedge clk);
    #1;
    check("busy at cnt 10", 32'(ex_stall_req), 32'd1);
    rst     = 1'b0;
    ex_inst = OpNop;
    #1;
    check("reset mid-op stall", 32'(ex_stall_req), 32'd0);
    check("reset mid-op wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    run_mop("MUL after reset", OpMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
